// File: rtl/psx_pkg.sv
`default_nettype none
// ============================================================================
//  psx_pkg
//  Shared constants, FSM encoding and reply-byte helper for the PSX pad device.
//  Revision: 1.0
// ============================================================================
package psx_pkg;

    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_DATA_MARK  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_ACK_WAIT  = 3'd3,
        ST_ACK_PULSE = 3'd4,
        ST_DONE      = 3'd5
    } psx_state_e;

    function automatic logic [7:0] psx_reply_byte(input logic [2:0]  idx,
                                                  input logic [7:0]  pad_id,
                                                  input logic [15:0] snap);
        logic [7:0] r;
        case (idx)
            3'd0:    r = 8'hFF;
            3'd1:    r = pad_id;
            3'd2:    r = PSX_DATA_MARK;
            3'd3:    r = snap[7:0];
            default: r = snap[15:8];
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psx_pad_device_if.sv
`default_nettype none
// ============================================================================
//  psx_pad_device_if
//  Controller link between PSX host (master) and pad device (slave).
//  Revision: 1.0
// ============================================================================
interface psx_pad_device_if;
    logic psx_clk;
    logic cmd;
    logic att;
    logic data;
    logic ack;

    modport master (output psx_clk, output cmd, output att, input data, input ack);
    modport slave  (input psx_clk, input cmd, input att, output data, output ack);
endinterface
`default_nettype wire

// File: rtl/psx_edge_sync.sv
`default_nettype none
// ============================================================================
//  psx_edge_sync
//  Two-flop synchronizer with registered rise/fall pulses aligned to sync_o.
//  Revision: 1.0
// ============================================================================
module psx_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic rise_q;
    logic fall_q;

    // Pulses are computed from the first stage so they line up with the
    // cycle in which sync_q first shows the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            rise_q <= meta_q & ~sync_q;
            fall_q <= ~meta_q & sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/psx_pad_device.sv
`default_nettype none
// ============================================================================
//  psx_pad_device
//  Emulated PSX digital pad; answers 0x01/0x42 polls with a 5-byte reply.
//  Option macro: PSX_PAD_CMD_CHECK_EN (validate command bytes 0 and 1).
//  Revision: 1.0
// ============================================================================
module psx_pad_device
    import psx_pkg::*;
#(
    parameter int         ACK_DELAY = 4,
    parameter int         ACK_WIDTH = 2,
    parameter logic [7:0] PAD_ID    = PSX_ID_DIGITAL
) (
    input  logic            clk,
    input  logic            rst_n,
    psx_pad_device_if.slave link,
    input  logic [15:0]     buttons_n_i,
    output logic            busy_o,
    output logic            xfer_done_o
);

    localparam logic [7:0] WAIT_LAST  = 8'(ACK_DELAY - 2);
    localparam logic [7:0] PULSE_LAST = 8'(ACK_WIDTH - 1);

    psx_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [15:0] snap_q, snap_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        data_q, data_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cmd_meta_q, cmd_sync_q;

    logic psx_sync, psx_rise, psx_fall;
    logic att_sync, att_rise, att_fall;
    logic w_cmd_bad;
    logic unused_edges;

    psx_edge_sync #(.RST_VAL(1'b1)) u_sync_psx_clk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (link.psx_clk),
        .sync_o (psx_sync),
        .rise_o (psx_rise),
        .fall_o (psx_fall)
    );

    psx_edge_sync #(.RST_VAL(1'b1)) u_sync_att (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (link.att),
        .sync_o (att_sync),
        .rise_o (att_rise),
        .fall_o (att_fall)
    );

    assign unused_edges = psx_sync ^ att_rise;

`ifdef PSX_PAD_CMD_CHECK_EN
    assign w_cmd_bad = ((idx_q == 3'd0) && (rx_q != PSX_CMD_START)) ||
                       ((idx_q == 3'd1) && (rx_q != PSX_CMD_POLL));
`else
    logic unused_rx;
    assign unused_rx = ^rx_q;
    assign w_cmd_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        snap_d    = snap_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_d     = 1'b0;

        // Host releasing att wins over anything else happening this cycle.
        if ((state_q != ST_IDLE) && att_sync) begin
            state_d   = ST_IDLE;
            data_d    = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            idx_d     = '0;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (att_fall) begin
                        snap_d    = buttons_n_i;
                        idx_d     = '0;
                        bit_cnt_d = '0;
                        tx_d      = 8'hFF;
                        busy_d    = 1'b1;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (psx_fall) begin
                        data_d = tx_q[0];
                        tx_d   = {1'b1, tx_q[7:1]};
                    end
                    if (psx_rise) begin
                        rx_d      = {cmd_sync_q, rx_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_CHECK;
                            done_d  = (idx_q == 3'd4);
                        end
                    end
                end
                ST_CHECK: begin
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    if (w_cmd_bad || (idx_q == 3'd4)) begin
                        state_d = ST_DONE;
                        data_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = psx_reply_byte(idx_q + 3'd1, PAD_ID, snap_q);
                        state_d = (ACK_DELAY > 1) ? ST_ACK_WAIT : ST_ACK_PULSE;
                    end
                end
                ST_ACK_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ACK_PULSE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_ACK_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    data_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ack_d = (state_d == ST_ACK_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            tx_q       <= 8'hFF;
            rx_q       <= '0;
            snap_q     <= 16'hFFFF;
            cnt_q      <= '0;
            data_q     <= 1'b1;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_meta_q <= 1'b1;
            cmd_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cmd_meta_q <= link.cmd;
            cmd_sync_q <= cmd_meta_q;
        end
    end

    assign link.data   = data_q;
    assign link.ack    = ack_q;
    assign busy_o      = busy_q;
    assign xfer_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_psx_pad_device.sv
`default_nettype none
// ============================================================================
//  tb_psx_pad_device
//  Randomized host model driving two pad instances (default and slow-ack).
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_psx_pad_device;
    import psx_pkg::*;

    localparam int HALF  = 4;
    localparam int GAP   = 24;
    localparam int DLY_A = 4, WID_A = 2, DLY_B = 6, WID_B = 3;
`ifdef PSX_PAD_CMD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef logic [7:0] frame_t [5];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] buttons_n = 16'hFFFF;
    logic        h_psx_clk = 1'b1, h_cmd = 1'b1, h_att = 1'b1;
    logic        busy_a, done_a, busy_b, done_b;
    int          n_tests = 0, n_fail = 0, cyc = 0;

    psx_pad_device_if if_a ();
    psx_pad_device_if if_b ();
    assign if_a.psx_clk = h_psx_clk;
    assign if_a.cmd     = h_cmd;
    assign if_a.att     = h_att;
    assign if_b.psx_clk = h_psx_clk;
    assign if_b.cmd     = h_cmd;
    assign if_b.att     = h_att;

    psx_pad_device dut_a (
        .clk(clk), .rst_n(rst_n), .link(if_a), .buttons_n_i(buttons_n),
        .busy_o(busy_a), .xfer_done_o(done_a)
    );
    psx_pad_device #(.ACK_DELAY(DLY_B), .ACK_WIDTH(WID_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .link(if_b), .buttons_n_i(buttons_n),
        .busy_o(busy_b), .xfer_done_o(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Ack / xfer_done observers, sampled on the falling clock edge
    int   ack_rise_a[$], ack_w_a[$], done_q_a[$];
    int   ack_rise_b[$], ack_w_b[$], done_q_b[$];
    int   run_a = 0, run_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        if (if_a.ack === 1'b1) begin
            if (!prev_a) ack_rise_a.push_back(cyc);
            run_a++;
        end else if (prev_a) begin
            ack_w_a.push_back(run_a);
            run_a = 0;
        end
        prev_a = (if_a.ack === 1'b1);
        if (if_b.ack === 1'b1) begin
            if (!prev_b) ack_rise_b.push_back(cyc);
            run_b++;
        end else if (prev_b) begin
            ack_w_b.push_back(run_b);
            run_b = 0;
        end
        prev_b = (if_b.ack === 1'b1);
        if (done_a === 1'b1) done_q_a.push_back(cyc);
        if (done_b === 1'b1) done_q_b.push_back(cyc);
    end

    // Reference model: what a host should read back for a given command frame
    function automatic void model(input frame_t cmds, input logic [15:0] btn,
                                  output frame_t exp, output int nack, output int ndone);
        frame_t tbl;
        int     live;
        tbl = '{8'hFF, PSX_ID_DIGITAL, 8'h5A, btn[7:0], btn[15:8]};
        if (!CHECK_EN)                    live = 5;
        else if (cmds[0] != 8'h01)        live = 1;
        else if (cmds[1] != 8'h42)        live = 2;
        else                              live = 5;
        for (int i = 0; i < 5; i++) exp[i] = (i < live) ? tbl[i] : 8'hFF;
        nack  = (live == 5) ? 4 : live - 1;
        ndone = (live == 5) ? 1 : 0;
    endfunction

    logic [7:0] rx_a, rx_b;
    int         t_rise8;
    logic       busy_s2, busy_s3, busy_e2, busy_e3;

    task automatic send_bits(input logic [7:0] c, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            h_psx_clk = 1'b0;
            h_cmd     = c[i];
            repeat (HALF) @(negedge clk);
            h_psx_clk = 1'b1;
            rx_a[i]   = if_a.data;
            rx_b[i]   = if_b.data;
            t_rise8   = cyc;
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic clear_obs();
        ack_rise_a.delete(); ack_w_a.delete(); done_q_a.delete();
        ack_rise_b.delete(); ack_w_b.delete(); done_q_b.delete();
    endtask

    task automatic run_frame(input frame_t cmds, input int chg_idx, input logic [15:0] chg_val,
                             output frame_t ra, output frame_t rb, output int t8 [5]);
        clear_obs();
        @(negedge clk);
        h_att = 1'b0;
        repeat (2) @(negedge clk);
        busy_s2 = busy_a;
        @(negedge clk);
        busy_s3 = busy_a;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            send_bits(cmds[k], 8);
            ra[k] = rx_a;
            rb[k] = rx_b;
            t8[k] = t_rise8;
            if (k == chg_idx) buttons_n = chg_val;
            repeat (GAP) @(negedge clk);
        end
        h_att = 1'b1;
        repeat (2) @(negedge clk);
        busy_e2 = busy_a;
        @(negedge clk);
        busy_e3 = busy_a;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (if_a.data !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b want 1", if_a.data); end
        n_tests++; if (if_a.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", if_a.ack); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_done: got %b want 0", done_a); end
        n_tests++; if (if_b.data !== 1'b1) begin n_fail++; $display("FAIL reset_data_b: got %b want 1", if_b.data); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_full_poll();
        frame_t c, ra, rb, ex;
        int t8 [5];
        int na, nd;
        c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        buttons_n = 16'hFFFE;
        model(c, buttons_n, ex, na, nd);
        run_frame(c, -1, 16'h0, ra, rb, t8);
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (ra[k] !== ex[k]) begin n_fail++; $display("FAIL poll_byte%0d: got %h want %h", k, ra[k], ex[k]); end
            n_tests++; if (rb[k] !== ex[k]) begin n_fail++; $display("FAIL poll_byte%0d_b: got %h want %h", k, rb[k], ex[k]); end
        end
        n_tests++; if (ack_w_a.size() != na) begin n_fail++; $display("FAIL poll_ack_count: got %0d want %0d", ack_w_a.size(), na); end
        foreach (ack_w_a[i]) begin
            n_tests++; if (ack_w_a[i] != WID_A) begin n_fail++; $display("FAIL poll_ack_width%0d: got %0d want %0d", i, ack_w_a[i], WID_A); end
        end
        n_tests++; if (done_q_a.size() != nd) begin n_fail++; $display("FAIL poll_xfer_done: got %0d want %0d", done_q_a.size(), nd); end
        n_tests++; if (busy_s2 !== 1'b0 || busy_s3 !== 1'b1) begin n_fail++; $display("FAIL poll_busy_rise: got %b%b want 01", busy_s2, busy_s3); end
        n_tests++; if (busy_e2 !== 1'b1 || busy_e3 !== 1'b0) begin n_fail++; $display("FAIL poll_busy_fall: got %b%b want 10", busy_e2, busy_e3); end
    endtask

    task automatic test_ack_timing();
        frame_t c, ra, rb;
        int t8 [5];
        c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        buttons_n = 16'($urandom);
        run_frame(c, -1, 16'h0, ra, rb, t8);
        // Pin change -> 2 synchronizer cycles, then ACK_DELAY+1 to ack
        n_tests++;
        if (ack_rise_a.size() != 4 || ack_rise_b.size() != 4 || ack_w_b.size() != 4) begin
            n_fail++; $display("FAIL ack_timing_count: got %0d/%0d want 4/4", ack_rise_a.size(), ack_rise_b.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_tests++; if (ack_rise_a[k] - t8[k] != DLY_A + 3) begin n_fail++; $display("FAIL ack_lat_a%0d: got %0d want %0d", k, ack_rise_a[k] - t8[k], DLY_A + 3); end
                n_tests++; if (ack_rise_b[k] - t8[k] != DLY_B + 3) begin n_fail++; $display("FAIL ack_lat_b%0d: got %0d want %0d", k, ack_rise_b[k] - t8[k], DLY_B + 3); end
                n_tests++; if (ack_w_b[k] != WID_B) begin n_fail++; $display("FAIL ack_width_b%0d: got %0d want %0d", k, ack_w_b[k], WID_B); end
            end
        end
        n_tests++;
        if (done_q_a.size() != 1 || done_q_b.size() != 1) begin
            n_fail++; $display("FAIL xfer_done_count: got %0d/%0d want 1/1", done_q_a.size(), done_q_b.size());
        end else begin
            n_tests++; if (done_q_a[0] - t8[4] != 3) begin n_fail++; $display("FAIL xfer_done_lat: got %0d want 3", done_q_a[0] - t8[4]); end
        end
    endtask

    task automatic test_bad_start();
        frame_t c, ra, rb, ex;
        int t8 [5];
        int na, nd;
        c = '{8'h03, 8'h42, 8'h00, 8'h00, 8'h00};
        buttons_n = 16'($urandom);
        model(c, buttons_n, ex, na, nd);
        run_frame(c, -1, 16'h0, ra, rb, t8);
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (ra[k] !== ex[k]) begin n_fail++; $display("FAIL bad_start_byte%0d: got %h want %h", k, ra[k], ex[k]); end
        end
        n_tests++; if (ack_w_a.size() != na) begin n_fail++; $display("FAIL bad_start_acks: got %0d want %0d", ack_w_a.size(), na); end
        n_tests++; if (done_q_a.size() != nd) begin n_fail++; $display("FAIL bad_start_done: got %0d want %0d", done_q_a.size(), nd); end
        n_tests++; if (busy_e3 !== 1'b0) begin n_fail++; $display("FAIL bad_start_busy: got %b want 0", busy_e3); end
    endtask

    task automatic test_abort();
        frame_t c, ra, rb, ex;
        int t8 [5];
        int na, nd;
        clear_obs();
        buttons_n = 16'($urandom);
        @(negedge clk);
        h_att = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h01, 8); repeat (GAP) @(negedge clk);
        send_bits(8'h42, 8); repeat (GAP) @(negedge clk);
        send_bits(8'h00, 4);
        @(negedge clk);
        h_att = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_a); end
        n_tests++; if (if_a.ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack: got %b want 0", if_a.ack); end
        n_tests++; if (if_a.data !== 1'b1) begin n_fail++; $display("FAIL abort_data: got %b want 1", if_a.data); end
        n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL abort_busy_b: got %b want 0", busy_b); end
        repeat (6) @(negedge clk);
        c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        buttons_n = 16'($urandom);
        model(c, buttons_n, ex, na, nd);
        run_frame(c, -1, 16'h0, ra, rb, t8);
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (ra[k] !== ex[k]) begin n_fail++; $display("FAIL after_abort_byte%0d: got %h want %h", k, ra[k], ex[k]); end
        end
        n_tests++; if (ack_w_a.size() != na) begin n_fail++; $display("FAIL after_abort_acks: got %0d want %0d", ack_w_a.size(), na); end
    endtask

    task automatic test_snapshot();
        frame_t c, ra, rb, ex;
        int t8 [5];
        int na, nd;
        c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        buttons_n = 16'hFFFF;
        model(c, buttons_n, ex, na, nd);
        run_frame(c, 1, 16'h0000, ra, rb, t8);
        for (int k = 3; k < 5; k++) begin
            n_tests++; if (ra[k] !== ex[k]) begin n_fail++; $display("FAIL snapshot_byte%0d: got %h want %h", k, ra[k], ex[k]); end
        end
    endtask

    task automatic test_random();
        frame_t c, ra, rb, ex;
        int t8 [5];
        int na, nd;
        for (int f = 0; f < 6; f++) begin
            c[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
            c[1] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h42;
            for (int k = 2; k < 5; k++) c[k] = 8'($urandom);
            buttons_n = 16'($urandom);
            model(c, buttons_n, ex, na, nd);
            run_frame(c, -1, 16'h0, ra, rb, t8);
            for (int k = 0; k < 5; k++) begin
                n_tests++; if (ra[k] !== ex[k]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, k, ra[k], ex[k]); end
                n_tests++; if (rb[k] !== ex[k]) begin n_fail++; $display("FAIL rand%0d_byte%0d_b: got %h want %h", f, k, rb[k], ex[k]); end
            end
            n_tests++; if (ack_w_a.size() != na) begin n_fail++; $display("FAIL rand%0d_acks: got %0d want %0d", f, ack_w_a.size(), na); end
            n_tests++; if (done_q_b.size() != nd) begin n_fail++; $display("FAIL rand%0d_done_b: got %0d want %0d", f, done_q_b.size(), nd); end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        h_att = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h01, 8);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (if_a.ack === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL async_reset_wait_ack: got no ack within 30 cycles want ack");
        end else begin
            #2 rst_n = 1'b0;
            #1;
            n_tests++; if (if_a.ack !== 1'b0) begin n_fail++; $display("FAIL async_reset_ack: got %b want 0", if_a.ack); end
            n_tests++; if (if_a.data !== 1'b1) begin n_fail++; $display("FAIL async_reset_data: got %b want 1", if_a.data); end
            n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy_a); end
            n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy_b: got %b want 0", busy_b); end
        end
        @(negedge clk);
        h_att = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_poll();
        test_ack_timing();
        test_bad_start();
        test_abort();
        test_snapshot();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
